// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//
// Interrupt controller sitting directly in front of the processor's
// `interrupt` input. Rising edges on the request lines are latched into a
// pending register. The lowest-index pending source is selected and
// announced with a PULSE_CYCLES-wide `interrupt` pulse. Its index is
// presented on `irq_id`, which feeds the processor in_port mux so the ISR
// can read it. No further service starts until the ISR retires with `eoi`.
// After `eoi`, a GUARD_CYCLES drain interval lets the pipeline settle.
//
// Parameters:
//   N_SRC        number of request lines (1..8)
//   W            width of irq_id
//   PULSE_CYCLES cycles `interrupt` stays high per service (>=1)
//   GUARD_CYCLES drain cycles after eoi before the next service (>=0)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   irq_in     request lines, already synchronous to clk
//   irq_mask   (IRQ_MASK_EN only) 1 = line excluded from selection
//   eoi        one-cycle end-of-interrupt strobe (RTI retire)
//   interrupt  to processor interrupt input
//   irq_id     zero-extended index of the source in service
//   busy       high whenever the controller is not IDLE
//   pending    current pending register
//
// Optional feature macro: IRQ_MASK_EN. When it is defined, the irq_mask
// port is added. Masked lines still become pending, but they are not
// selected until they are unmasked.
// ---------------------------------------------------------------------------

// Per-line edge detector and pending bit.
module irq_src_cell (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    input  logic clr_i,
    output logic pend_o
);
    logic prev_q;
    logic pend_q;
    logic rise;

    assign rise = irq_i & ~prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            // prev is preset high so a line held high through reset
            // does not look like a fresh edge.
            prev_q <= 1'b1;
            pend_q <= 1'b0;
        end else begin
            prev_q <= irq_i;
            // A new edge in the same cycle as the clear wins, so that
            // request is not lost.
            pend_q <= rise | (pend_q & ~clr_i);
        end
    end

    assign pend_o = pend_q;
endmodule

module irq_controller #(
    parameter int N_SRC        = 4,
    parameter int W            = 16,
    parameter int PULSE_CYCLES = 1,
    parameter int GUARD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
`ifdef IRQ_MASK_EN
    input  logic [N_SRC-1:0] irq_mask,
`endif
    input  logic             eoi,
    output logic             interrupt,
    output logic [W-1:0]     irq_id,
    output logic             busy,
    output logic [N_SRC-1:0] pending
);
    localparam int CNT_MAX = (PULSE_CYCLES > GUARD_CYCLES) ? PULSE_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int SEL_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD =
        (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        WAIT_EOI = 2'd2,
        GUARD    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               int_q, int_d;
    logic [W-1:0]       id_q, id_d;

    logic [N_SRC-1:0]   clr;
    logic [N_SRC-1:0]   elig;
    logic [SEL_W-1:0]   sel;
    logic               any_elig;

    // ---------------- per-line pending cells ----------------
    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        irq_src_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .irq_i  (irq_in[g]),
            .clr_i  (clr[g]),
            .pend_o (pending[g])
        );
    end

`ifdef IRQ_MASK_EN
    assign elig = pending & ~irq_mask;
`else
    assign elig = pending;
`endif

    // Lowest set index has priority. Scan downward so the last hit wins.
    always_comb begin
        sel      = '0;
        any_elig = |elig;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) sel = SEL_W'(i);
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        int_d   = int_q;
        id_d    = id_q;
        clr     = '0;

        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    clr[sel] = 1'b1;
                    id_d     = W'(sel);
                    cnt_d    = PULSE_LOAD;
                    int_d    = 1'b1;
                    state_d  = ASSERT;
                end
            end
            ASSERT: begin
                // eoi is deliberately ignored while the pulse is running.
                if (cnt_q == '0) begin
                    int_d   = 1'b0;
                    state_d = WAIT_EOI;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_EOI: begin
                if (eoi) begin
                    if (GUARD_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = GUARD_LOAD;
                        state_d = GUARD;
                    end
                end
            end
            GUARD: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            int_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            int_q   <= int_d;
            id_q    <= id_d;
        end
    end

    assign interrupt = int_q;
    assign irq_id    = id_q;       // held until the next selection
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_irq_controller.sv
// Two DUTs share stimulus: A (PULSE=1, GUARD=4) and B (PULSE=3, GUARD=0).
// The reference model tracks absolute cycle times for service milestones
// rather than states.
module tb_irq_controller;
    localparam int N   = 4;
    localparam int W   = 16;
    localparam int INF = 32'h3fffffff;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         eoi = 1'b0;
    logic [N-1:0] irq_in = '0;
`ifdef IRQ_MASK_EN
    logic [N-1:0] irq_mask = '0;
`endif

    logic         int_a, int_b, busy_a, busy_b;
    logic [W-1:0] id_a, id_b;
    logic [N-1:0] pend_a, pend_b;

    always #5 clk = ~clk;

    irq_controller #(.N_SRC(N), .W(W), .PULSE_CYCLES(1), .GUARD_CYCLES(4)) u_a (
        .clk(clk), .rst(rst), .irq_in(irq_in),
`ifdef IRQ_MASK_EN
        .irq_mask(irq_mask),
`endif
        .eoi(eoi), .interrupt(int_a), .irq_id(id_a), .busy(busy_a), .pending(pend_a)
    );

    irq_controller #(.N_SRC(N), .W(W), .PULSE_CYCLES(3), .GUARD_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .irq_in(irq_in),
`ifdef IRQ_MASK_EN
        .irq_mask(irq_mask),
`endif
        .eoi(eoi), .interrupt(int_b), .irq_id(id_b), .busy(busy_b), .pending(pend_b)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model, one slot per DUT.
    int           pc[2] = '{1, 3};
    int           gc[2] = '{4, 0};
    logic [N-1:0] m_pend[2];
    logic [N-1:0] m_prev[2];
    int           m_id[2];
    int           m_int_until[2];  // last edge after which interrupt is high
    int           m_eoi_from[2];   // first edge at which eoi is honoured
    int           m_idle_at[2];    // first edge evaluated as idle (INF = waiting eoi)

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic m_busy(input int k);
        return !(cyc + 1 >= m_idle_at[k]);
    endfunction

    function automatic logic m_int(input int k);
        return cyc <= m_int_until[k];
    endfunction

    task automatic model_edge();
        logic [N-1:0] msk, rise, clr, elig;
        int sel;
        cyc++;
`ifdef IRQ_MASK_EN
        msk = irq_mask;
`else
        msk = '0;
`endif
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_pend[k]      = '0;
                m_prev[k]      = '1;
                m_id[k]        = 0;
                m_int_until[k] = -1;
                m_eoi_from[k]  = INF;
                m_idle_at[k]   = cyc + 1;
            end else begin
                rise = irq_in & ~m_prev[k];
                clr  = '0;
                elig = m_pend[k] & ~msk;
                sel  = -1;
                for (int i = 0; i < N; i++)
                    if (elig[i] && sel < 0) sel = i;
                if (cyc >= m_idle_at[k] && sel >= 0) begin
                    clr[sel]       = 1'b1;
                    m_id[k]        = sel;
                    m_int_until[k] = cyc + pc[k] - 1;
                    m_eoi_from[k]  = cyc + pc[k] + 1;
                    m_idle_at[k]   = INF;
                end else if (eoi && m_idle_at[k] == INF && cyc >= m_eoi_from[k]) begin
                    m_idle_at[k] = cyc + gc[k] + 1;
                end
                m_pend[k] = rise | (m_pend[k] & ~clr);
                m_prev[k] = irq_in;
            end
        end
    endtask

    task automatic check_all();
        chk("a.interrupt", 32'(int_a),  32'(m_int(0)));
        chk("a.irq_id",    32'(id_a),   32'(m_id[0]));
        chk("a.busy",      32'(busy_a), 32'(m_busy(0)));
        chk("a.pending",   32'(pend_a), 32'(m_pend[0]));
        chk("b.interrupt", 32'(int_b),  32'(m_int(1)));
        chk("b.irq_id",    32'(id_b),   32'(m_id[1]));
        chk("b.busy",      32'(busy_b), 32'(m_busy(1)));
        chk("b.pending",   32'(pend_b), 32'(m_pend[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Let every outstanding request be served and retired.
    task automatic drain();
        logic done;
        done   = 1'b0;
        irq_in = '0;
`ifdef IRQ_MASK_EN
        irq_mask = '0;
`endif
        for (int n = 0; n < 80 && !done; n++) begin
            eoi = n[0];
            step();
            done = !m_busy(0) && !m_busy(1) && m_pend[0] == '0 && m_pend[1] == '0;
        end
        eoi = 1'b0;
        chk("drain_done", 32'(done), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = '0; m_prev[k] = '1; m_id[k] = 0;
            m_int_until[k] = -1; m_eoi_from[k] = INF; m_idle_at[k] = 0;
        end

        // 1) Line held high through reset raises no request.
        rst = 1'b0; irq_in = 4'b0010;
        step(); step();
        rst = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            chk("held.interrupt", 32'(int_a),  32'd0);
            chk("held.pending",   32'(pend_a), 32'd0);
        end
        irq_in = 4'b0000; step();
        irq_in = 4'b0010; step();
        chk("t1.pending",   32'(pend_a), 32'h2);
        chk("t1.int_early", 32'(int_a),  32'd0);
        step();
        chk("t1.interrupt", 32'(int_a), 32'd1);
        chk("t1.irq_id",    32'(id_a),  32'h1);
        step();
        eoi = 1'b1; step(); eoi = 1'b0;
        // B is still in its 3-cycle pulse, so the eoi is ignored.
        chk("t1.b_int_3rd",  32'(int_b),  32'd1);
        chk("t1.b_busy",     32'(busy_b), 32'd1);
        step();
        chk("t1.b_int_done", 32'(int_b),  32'd0);
        chk("t1.b_busy2",    32'(busy_b), 32'd1);
        drain();

        // 2) Simultaneous edges on 3 and 0: line 0 first, then 3 after the guard.
        irq_in = 4'b1001; step();
        chk("t2.pending0", 32'(pend_a), 32'h9);
        step();
        chk("t2.int0",     32'(int_a),  32'd1);
        chk("t2.id0",      32'(id_a),   32'h0);
        chk("t2.pending1", 32'(pend_a), 32'h8);
        step();
        eoi = 1'b1; step(); eoi = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("t2.guard_int", 32'(int_a), 32'd0);
        end
        step();
        chk("t2.int3", 32'(int_a), 32'd1);
        chk("t2.id3",  32'(id_a),  32'h3);
        drain();

        // 3) New edge on line 2 in the same cycle as its clear.
        irq_in = 4'b0001; step(); step(); step();
        eoi = 1'b1; step(); eoi = 1'b0;           // edge e
        irq_in = 4'b0100; step();                  // e+1: pending[2] set
        irq_in = 4'b0000; step(); step(); step();  // e+2..e+4
        irq_in = 4'b0100; step();                  // e+5: select + new rise
        chk("t3.int",      32'(int_a),  32'd1);
        chk("t3.id",       32'(id_a),   32'h2);
        chk("t3.set_wins", 32'(pend_a), 32'h4);
        step();
        eoi = 1'b1; step(); eoi = 1'b0;
        for (int n = 0; n < 4; n++) step();
        step();
        chk("t3.int2",  32'(int_a),  32'd1);
        chk("t3.id2",   32'(id_a),   32'h2);
        chk("t3.pend2", 32'(pend_a), 32'h0);
        drain();

        // 4) Reset while waiting for eoi.
        irq_in = 4'b0110; step(); step(); step();
        chk("t4.busy_pre", 32'(busy_a), 32'd1);
        rst = 1'b0; step();
        chk("t4.busy",      32'(busy_a), 32'd0);
        chk("t4.interrupt", 32'(int_a),  32'd0);
        chk("t4.pending",   32'(pend_a), 32'd0);
        chk("t4.irq_id",    32'(id_a),   32'd0);
        rst = 1'b1; irq_in = 4'b0000; step();
        drain();

`ifdef IRQ_MASK_EN
        // 5) Masked line pends but is not served until unmasked.
        irq_mask = 4'b0001; irq_in = 4'b0001; step();
        chk("t5.pending", 32'(pend_a), 32'h1);
        step(); step();
        chk("t5.masked_int", 32'(int_a), 32'd0);
        irq_mask = 4'b0000; step();
        chk("t5.int", 32'(int_a), 32'd1);
        chk("t5.id",  32'(id_a),  32'h0);
        drain();
`endif

        // 6) Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            irq_in = irq_in ^ (4'($urandom) & 4'($urandom));
            eoi    = ($urandom_range(0, 3) == 0);
            rst    = ($urandom_range(0, 149) != 0);
`ifdef IRQ_MASK_EN
            if ($urandom_range(0, 7) == 0) irq_mask = 4'($urandom);
`endif
            step();
        end
        rst = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
